// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, WIDTH steps per op.
// Optional MCYCLE_SIGNED_EN builds signed operation (MCycleOp[1]); otherwise everything is unsigned.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     op1_raw;
  logic                 op_div, div0;
  logic                 last;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH-1:0]     fin1, fin2;
  logic [WIDTH:0]       mul_sum, div_trial;

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          Busy      = 1'b1;
          state_nxt = COMPUTING;
        end
      end
      COMPUTING: begin
        Busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc holds {partial, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : '0)};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
    if (!op_div)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {acc[2*WIDTH-2:0], 1'b0};
  end

`ifdef MCYCLE_SIGNED_EN
  logic s1, s2, s1_in, s2_in;

  assign s1_in = MCycleOp[1] & Operand1[WIDTH-1];
  assign s2_in = MCycleOp[1] & Operand2[WIDTH-1];
  assign mag1  = s1_in ? -Operand1 : Operand1;
  assign mag2  = s2_in ? -Operand2 : Operand2;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (state == IDLE && Start) begin
      s1 <= s1_in;
      s2 <= s2_in;
    end
  end

  // Most-negative / -1 falls out naturally: 2^(W-1) negated wraps back to most-negative
  always_comb begin
    fin1 = acc_next[WIDTH-1:0];
    fin2 = acc_next[2*WIDTH-1:WIDTH];
    if (!op_div) begin
      if (s1 ^ s2) {fin2, fin1} = -acc_next;
    end else begin
      if (s1 ^ s2) fin1 = -acc_next[WIDTH-1:0];
      if (s1)      fin2 = -acc_next[2*WIDTH-1:WIDTH];
    end
  end
`else
  logic unused_sign_sel;

  assign unused_sign_sel = MCycleOp[1];
  assign mag1 = Operand1;
  assign mag2 = Operand2;
  assign fin1 = acc_next[WIDTH-1:0];
  assign fin2 = acc_next[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      count   <= '0;
      acc     <= '0;
      m       <= '0;
      op1_raw <= '0;
      op_div  <= 1'b0;
      div0    <= 1'b0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            acc     <= MCycleOp[0] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
            m       <= MCycleOp[0] ? mag2 : mag1;
            op_div  <= MCycleOp[0];
            div0    <= (Operand2 == '0);
            op1_raw <= Operand1;
            count   <= '0;
          end
        end
        COMPUTING: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (last) begin
            Result1 <= (op_div && div0) ? '1      : fin1;
            Result2 <= (op_div && div0) ? op1_raw : fin2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit (WIDTH=32): vector table plus reset/back-to-back sequences.
// Expected results follow the build's MCYCLE_SIGNED_EN setting.
module tb_mcycle_unit;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, e1, e2;
  } vec_t;

  typedef struct {
    logic [31:0] r1, r2;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  exp_t exp_q[$];

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r1, output logic [31:0] r2);
    bit          sg;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sg = op[1];
`ifndef MCYCLE_SIGNED_EN
    sg = 1'b0;
`endif
    if (!op[0]) begin
      if (sg) p = longint'($signed(a)) * longint'($signed(b));
      else    p = {32'b0, a} * {32'b0, b};
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (b == 32'd0) begin
      r1 = 32'hFFFF_FFFF;
      r2 = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      r1 = q[31:0];
      r2 = r[31:0];
    end else begin
      r1 = a / b;
      r2 = a % b;
    end
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  // Drives one op; from_done means the previous op left Start high in DONE.
  task automatic run_op(input vec_t v, input bit from_done, input bit hold);
    int   lat;
    exp_t e;
    e.r1 = v.e1;
    e.r2 = v.e2;
    exp_q.push_back(e);
    MCycleOp = v.op;
    Operand1 = v.a;
    Operand2 = v.b;
    Start    = 1'b1;
    #1;
    if (from_done) begin
      check("busy_in_done_start_high", 64'(Busy), 64'd0);
      @(posedge CLK); #1;
    end
    lat = 0;
    while (Busy && lat < 100) begin
      lat++;
      @(posedge CLK); #1;
      Operand1 = $urandom;
      Operand2 = $urandom;
      MCycleOp = 2'($urandom);
    end
    check("busy_span", 64'(lat), 64'd33);
    e = exp_q.pop_front();
    check("result1", 64'(Result1), 64'(e.r1));
    check("result2", 64'(Result2), 64'(e.r2));
    if (!hold) begin
      Start = 1'b0;
      @(posedge CLK); #1;
      check("busy_after_retire", 64'(Busy), 64'd0);
      check("result1_hold", 64'(Result1), 64'(e.r1));
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, e1, e2;

    vecs.push_back(mk(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE));
    vecs.push_back(mk(2'b01, 32'd100,       32'd7,         32'd14,        32'd2));
    vecs.push_back(mk(2'b01, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234));
    vecs.push_back(mk(2'b11, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF00));
    vecs.push_back(mk(2'b00, 32'd0,         32'h1234_5678, 32'd0,         32'd0));
`ifdef MCYCLE_SIGNED_EN
    vecs.push_back(mk(2'b10, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF));
    vecs.push_back(mk(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF));
    vecs.push_back(mk(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0));
    vecs.push_back(mk(2'b11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1));
`else
    vecs.push_back(mk(2'b10, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'd6));
    vecs.push_back(mk(2'b11, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1));
    vecs.push_back(mk(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000));
    vecs.push_back(mk(2'b11, 32'd7,         32'hFFFF_FFFE, 32'd0,         32'd7));
`endif
    for (int i = 0; i < 12; i++) begin
      rop = 2'(i);
      ra  = $urandom;
      rb  = (i % 5 == 4) ? 32'($urandom_range(1, 300)) : $urandom;
      model(rop, ra, rb, e1, e2);
      vecs.push_back(mk(rop, ra, rb, e1, e2));
    end

    RESETn = 1'b0; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_r1", 64'(Result1), 64'd0);
    check("reset_r2", 64'(Result2), 64'd0);
    RESETn = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i], (i % 3 == 2), (i % 3 == 1));

    // Reset in the middle of an operation, with earlier nonzero results present
    run_op(mk(2'b00, 32'd1000, 32'd3, 32'd3000, 32'd0), 1'b0, 1'b0);
    MCycleOp = 2'b00; Operand1 = 32'd5; Operand2 = 32'd6; Start = 1'b1;
    @(posedge CLK); #1;
    repeat (9) @(posedge CLK);
    #1;
    check("busy_mid_op", 64'(Busy), 64'd1);
    RESETn = 1'b0; Start = 1'b0;
    @(posedge CLK); #1;
    check("midreset_busy", 64'(Busy), 64'd0);
    check("midreset_r1", 64'(Result1), 64'd0);
    check("midreset_r2", 64'(Result2), 64'd0);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_idle", 64'(Busy), 64'd0);
    run_op(mk(2'b01, 32'd100, 32'd7, 32'd14, 32'd2), 1'b0, 1'b0);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
